// File: rtl/display_mode_controller.sv
// Screen sequencer for the occupancy/temperature display mux: key debounce,
// splash screen, navigation/edit state machine, inactivity timeout and alert.
module display_mode_controller #(
   parameter int unsigned DEBOUNCE_TICKS = 3,
   parameter int unsigned SPLASH_TICKS   = 200,
   parameter int unsigned TIMEOUT_TICKS  = 1000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Tick10ms,
   input  logic       KeyNext,
   input  logic       KeyBack,
   input  logic       KeyInc,
   input  logic       Alarm,
   output logic [7:0] Selector,
   output logic       Increment,
   output logic       Editing
);

   localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
   localparam int unsigned SW = $clog2(SPLASH_TICKS + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [DW-1:0] DebMax = DW'(DEBOUNCE_TICKS);
   localparam logic [SW-1:0] SplMax = SW'(SPLASH_TICKS);
   localparam logic [TW-1:0] TmoMax = TW'(TIMEOUT_TICKS);

   typedef enum logic [2:0] {
      StSplash, StHome, StTemp, StPerson, StRoom, StEditP, StEditR, StAlert
   } state_e;

   function automatic logic [7:0] sel_code(state_e s);
      unique case (s)
         StSplash: sel_code = 8'd1;
         StHome:   sel_code = 8'd0;
         StTemp:   sel_code = 8'd3;
         StPerson: sel_code = 8'd4;
         StRoom:   sel_code = 8'd5;
         StEditP:  sel_code = 8'd20;
         StEditR:  sel_code = 8'd21;
         StAlert:  sel_code = 8'd6;
         default:  sel_code = 8'd0;
      endcase
   endfunction

   // Key bit order everywhere: {inc, back, next}; key levels are 1 when released.
   logic [2:0]         key_s1_q, key_s2_q;
   logic               alarm_s1_q, alarm_s2_q;
   logic [2:0][DW-1:0] deb_cnt_q, deb_cnt_d;
   logic [2:0]         deb_acc_q, deb_acc_d;
   logic [2:0]         ev_q, ev_d;
   state_e             state_q, state_d;
   logic [SW-1:0]      spl_q, spl_d;
   logic [TW-1:0]      tmo_q, tmo_d;
   logic [7:0]         sel_q;
   logic               inc_q, inc_d;
   logic               edit_q;
   logic               ev_nx, ev_bk, ev_in;

   // Two-flop synchronizers for the raw keys and the alarm level.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         key_s1_q   <= 3'b111;
         key_s2_q   <= 3'b111;
         alarm_s1_q <= 1'b0;
         alarm_s2_q <= 1'b0;
      end else begin
         key_s1_q   <= {KeyInc, KeyBack, KeyNext};
         key_s2_q   <= key_s1_q;
         alarm_s1_q <= Alarm;
         alarm_s2_q <= alarm_s1_q;
      end
   end

   // Per-key debounce; the accepted flag starts set so a key held through reset
   // has to be seen released before it can fire.
   always_comb begin
      deb_cnt_d = deb_cnt_q;
      deb_acc_d = deb_acc_q;
      ev_d      = 3'b000;
      for (int k = 0; k < 3; k++) begin
         if (Tick10ms) begin
            if (!key_s2_q[k]) begin
               if (deb_cnt_q[k] != DebMax) deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
               if (deb_cnt_d[k] == DebMax && !deb_acc_q[k]) begin
                  ev_d[k]      = 1'b1;
                  deb_acc_d[k] = 1'b1;
               end
            end else begin
               deb_cnt_d[k] = '0;
               deb_acc_d[k] = 1'b0;
            end
         end
      end
   end

   // Debounce state and the registered one-cycle press events.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         deb_cnt_q <= '0;
         deb_acc_q <= 3'b111;
         ev_q      <= 3'b000;
      end else begin
         deb_cnt_q <= deb_cnt_d;
         deb_acc_q <= deb_acc_d;
         ev_q      <= ev_d;
      end
   end

   assign ev_nx = ev_q[0];
   assign ev_bk = ev_q[1] & ~ev_q[0];
   assign ev_in = ev_q[2] & ~ev_q[1] & ~ev_q[0];

   // Next-state, splash/timeout counters and increment strobe.
   always_comb begin
      state_d = state_q;
      spl_d   = spl_q;
      inc_d   = 1'b0;
      unique case (state_q)
         StSplash: begin
            if (Tick10ms && spl_q != SplMax) spl_d = spl_q + 1'b1;
            if (spl_q == SplMax) state_d = alarm_s2_q ? StAlert : StHome;
         end
         StAlert: begin
            if (!alarm_s2_q) state_d = StHome;
         end
         default: begin
            if (alarm_s2_q) begin
               state_d = StAlert;
            end else if (|ev_q) begin
               unique case (state_q)
                  StHome: begin
                     if (ev_nx)      state_d = StTemp;
                     else if (ev_bk) state_d = StRoom;
                  end
                  StTemp: begin
                     if (ev_nx)      state_d = StPerson;
                     else if (ev_bk) state_d = StHome;
                  end
                  StPerson: begin
                     if (ev_nx)      state_d = StRoom;
                     else if (ev_bk) state_d = StTemp;
                     else if (ev_in) state_d = StEditP;
                  end
                  StRoom: begin
                     if (ev_nx)      state_d = StHome;
                     else if (ev_bk) state_d = StPerson;
                     else if (ev_in) state_d = StEditR;
                  end
                  StEditP: begin
                     if (ev_nx || ev_bk) state_d = StPerson;
                     else            inc_d   = ev_in;
                  end
                  StEditR: begin
                     if (ev_nx || ev_bk) state_d = StRoom;
                     else            inc_d   = ev_in;
                  end
                  default: ;
               endcase
            end else if (tmo_q == TmoMax && state_q != StHome) begin
               state_d = StHome;
            end
         end
      endcase

      // Inactivity counter: frozen in splash/alert, saturates (and so holds) in home.
      tmo_d = tmo_q;
      if ((|ev_q) || (state_d != state_q)) begin
         tmo_d = '0;
      end else if (Tick10ms && tmo_q != TmoMax && state_q != StSplash && state_q != StAlert) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= StSplash;
         spl_q   <= '0;
         tmo_q   <= '0;
         sel_q   <= 8'd1;
         inc_q   <= 1'b0;
         edit_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         spl_q   <= spl_d;
         tmo_q   <= tmo_d;
         sel_q   <= sel_code(state_d);
         inc_q   <= inc_d;
         edit_q  <= (state_d == StEditP) || (state_d == StEditR);
      end
   end

   assign Selector  = sel_q;
   assign Increment = inc_q;
   assign Editing   = edit_q;

endmodule

// File: tb/tb_display_mode_controller.sv
// Directed bench for display_mode_controller: one instance with a long timeout
// for navigation/edit/alarm work, one with a short timeout for the timeout cases.
module tb_display_mode_controller;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0;
   logic       key_next = 1'b1;
   logic       key_back = 1'b1;
   logic       key_inc = 1'b1;
   logic       alarm = 1'b0;
   logic [7:0] selector, selector_t;
   logic       increment, increment_t;
   logic       editing, editing_t;

   int checks = 0;
   int errors = 0;
   int inc_cnt = 0;
   int inc_consec = 0;
   logic inc_prev = 1'b0;

   display_mode_controller #(
      .DEBOUNCE_TICKS(2), .SPLASH_TICKS(4), .TIMEOUT_TICKS(1000)
   ) dut (
      .Clock(clock), .Reset(reset_n), .Tick10ms(tick), .KeyNext(key_next),
      .KeyBack(key_back), .KeyInc(key_inc), .Alarm(alarm),
      .Selector(selector), .Increment(increment), .Editing(editing)
   );

   display_mode_controller #(
      .DEBOUNCE_TICKS(2), .SPLASH_TICKS(4), .TIMEOUT_TICKS(5)
   ) dut_t (
      .Clock(clock), .Reset(reset_n), .Tick10ms(tick), .KeyNext(key_next),
      .KeyBack(key_back), .KeyInc(key_inc), .Alarm(alarm),
      .Selector(selector_t), .Increment(increment_t), .Editing(editing_t)
   );

   always #5 clock = ~clock;

   // Count Increment pulses and any back-to-back assertion.
   always @(negedge clock) begin
      if (increment) inc_cnt++;
      if (increment && inc_prev) inc_consec++;
      inc_prev = increment;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic tick1();
      @(negedge clock) tick = 1'b1;
      @(negedge clock) tick = 1'b0;
      cycles(3);
   endtask

   task automatic ticks(input int n);
      repeat (n) tick1();
   endtask

   task automatic set_key(input int k, input logic v);
      @(negedge clock);
      if (k == 0) key_next = v;
      else if (k == 1) key_back = v;
      else key_inc = v;
      cycles(3);
   endtask

   // Hold key k for n pressed samples, release, then take one released sample.
   task automatic press(input int k, input int n);
      set_key(k, 1'b0);
      ticks(n);
      set_key(k, 1'b1);
      tick1();
   endtask

   task automatic restart_to_home();
      @(negedge clock) reset_n = 1'b0;
      cycles(2);
      reset_n = 1'b1;
      cycles(2);
      ticks(4);
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      cycles(2);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (selector !== 8'd1) begin errors++; $display("FAIL reset_sel: got %0d required 1", selector); end
      checks++; if (increment !== 1'b0 || editing !== 1'b0) begin errors++; $display("FAIL reset_flags: got inc=%b edit=%b required 0 0", increment, editing); end
      cycles(2);
   endtask

   task automatic test_splash();
      @(negedge clock) reset_n = 1'b1;
      cycles(2);
      ticks(3);
      checks++; if (selector !== 8'd1) begin errors++; $display("FAIL splash_hold: got %0d required 1", selector); end
      tick1();
      checks++; if (selector !== 8'd0) begin errors++; $display("FAIL splash_end: got %0d required 0", selector); end
   endtask

   task automatic test_navigation();
      logic [7:0] exp_seq [4] = '{8'd3, 8'd4, 8'd5, 8'd0};
      for (int i = 0; i < 4; i++) begin
         press(0, 2);
         checks++; if (selector !== exp_seq[i]) begin errors++; $display("FAIL nav_next%0d: got %0d required %0d", i, selector, exp_seq[i]); end
      end
      press(1, 2);
      checks++; if (selector !== 8'd5) begin errors++; $display("FAIL nav_back: got %0d required 5", selector); end
   endtask

   task automatic test_debounce();
      press(0, 1);
      checks++; if (selector !== 8'd5) begin errors++; $display("FAIL deb_short: got %0d required 5", selector); end
      press(0, 2);
      checks++; if (selector !== 8'd0) begin errors++; $display("FAIL deb_two: got %0d required 0", selector); end
      press(0, 50);
      checks++; if (selector !== 8'd3) begin errors++; $display("FAIL deb_hold: got %0d required 3", selector); end
   endtask

   task automatic test_edit();
      inc_cnt = 0;
      press(2, 2);
      checks++; if (selector !== 8'd3 || inc_cnt !== 0) begin errors++; $display("FAIL edit_inc_temp: got sel=%0d pulses=%0d required 3 0", selector, inc_cnt); end
      press(0, 2);
      press(2, 2);
      checks++; if (selector !== 8'd20 || editing !== 1'b1) begin errors++; $display("FAIL edit_enter: got sel=%0d edit=%b required 20 1", selector, editing); end
      inc_cnt = 0; inc_consec = 0;
      for (int i = 0; i < 3; i++) press(2, 2);
      checks++; if (inc_cnt !== 3 || inc_consec !== 0) begin errors++; $display("FAIL edit_pulses: got %0d pulses %0d consecutive required 3 0", inc_cnt, inc_consec); end
      checks++; if (selector !== 8'd20) begin errors++; $display("FAIL edit_stay: got %0d required 20", selector); end
      press(1, 2);
      checks++; if (selector !== 8'd4 || editing !== 1'b0) begin errors++; $display("FAIL edit_back: got sel=%0d edit=%b required 4 0", selector, editing); end
   endtask

   task automatic test_priority();
      inc_cnt = 0;
      @(negedge clock) begin key_next = 1'b0; key_inc = 1'b0; end
      cycles(3);
      ticks(2);
      @(negedge clock) begin key_next = 1'b1; key_inc = 1'b1; end
      cycles(3);
      tick1();
      checks++; if (selector !== 8'd5 || inc_cnt !== 0) begin errors++; $display("FAIL priority: got sel=%0d pulses=%0d required 5 0", selector, inc_cnt); end
   endtask

   task automatic test_held_at_reset();
      @(negedge clock) key_inc = 1'b0;
      restart_to_home();
      press(0, 2);
      press(0, 2);
      ticks(3);
      checks++; if (selector !== 8'd4 || editing !== 1'b0) begin errors++; $display("FAIL held_ignored: got sel=%0d edit=%b required 4 0", selector, editing); end
      set_key(2, 1'b1);
      tick1();
      press(2, 2);
      checks++; if (selector !== 8'd20) begin errors++; $display("FAIL held_repress: got %0d required 20", selector); end
   endtask

   task automatic test_timeout();
      restart_to_home();
      press(1, 2);
      press(2, 2);
      ticks(3);
      checks++; if (selector_t !== 8'd21) begin errors++; $display("FAIL tmo_before: got %0d required 21", selector_t); end
      tick1();
      checks++; if (selector_t !== 8'd0) begin errors++; $display("FAIL tmo_fire: got %0d required 0", selector_t); end
      checks++; if (selector !== 8'd21) begin errors++; $display("FAIL tmo_long: got %0d required 21", selector); end
      // Re-enter EDIT_R, then an Inc press completing on the 4th tick restarts the count.
      press(1, 2);
      press(2, 2);
      tick1();
      set_key(2, 1'b0);
      ticks(2);
      set_key(2, 1'b1);
      ticks(4);
      checks++; if (selector_t !== 8'd21) begin errors++; $display("FAIL tmo_restart: got %0d required 21", selector_t); end
      tick1();
      checks++; if (selector_t !== 8'd0) begin errors++; $display("FAIL tmo_refire: got %0d required 0", selector_t); end
   endtask

   task automatic test_alarm();
      restart_to_home();
      press(0, 2);
      press(0, 2);
      press(2, 2);
      checks++; if (selector !== 8'd20) begin errors++; $display("FAIL alarm_setup: got %0d required 20", selector); end
      inc_cnt = 0;
      @(negedge clock) alarm = 1'b1;
      cycles(3);
      checks++; if (selector !== 8'd6 || editing !== 1'b0) begin errors++; $display("FAIL alarm_enter: got sel=%0d edit=%b required 6 0", selector, editing); end
      press(0, 2);
      press(2, 2);
      checks++; if (selector !== 8'd6 || inc_cnt !== 0) begin errors++; $display("FAIL alarm_keys: got sel=%0d pulses=%0d required 6 0", selector, inc_cnt); end
      @(negedge clock) alarm = 1'b0;
      cycles(4);
      checks++; if (selector !== 8'd0) begin errors++; $display("FAIL alarm_clear: got %0d required 0", selector); end
   endtask

   task automatic test_alarm_splash();
      @(negedge clock) begin reset_n = 1'b0; alarm = 1'b1; end
      cycles(2);
      reset_n = 1'b1;
      cycles(2);
      ticks(3);
      checks++; if (selector !== 8'd1) begin errors++; $display("FAIL alarm_splash_hold: got %0d required 1", selector); end
      tick1();
      checks++; if (selector !== 8'd6) begin errors++; $display("FAIL alarm_splash_end: got %0d required 6", selector); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (selector !== 8'd1 || editing !== 1'b0 || increment !== 1'b0) begin errors++; $display("FAIL alarm_reset: got sel=%0d edit=%b inc=%b required 1 0 0", selector, editing, increment); end
      alarm = 1'b0;
      cycles(2);
   endtask

   initial begin
      test_reset();
      test_splash();
      test_navigation();
      test_debounce();
      test_edit();
      test_priority();
      test_held_at_reset();
      test_timeout();
      test_alarm();
      test_alarm_splash();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
